// File: rtl/rc_pwm_pkg.sv
// rtl/rc_pwm_pkg.sv - default constants and position helpers for rc_pwm_multi
package rc_pwm_pkg;

   localparam int unsigned DEF_CLK_DIV     = 1953;
   localparam int unsigned DEF_FRAME_TICKS = 512;
   localparam int unsigned DEF_POS_W       = 8;
   localparam int unsigned DEF_MIN_POS     = 50;
   localparam int unsigned DEF_MAX_POS     = 100;
   localparam int unsigned DEF_NEUTRAL     = 75;
   localparam int unsigned DEF_SLEW_STEP   = 2;

   function automatic int unsigned clamp_pos(input int unsigned pos,
                                             input int unsigned lo,
                                             input int unsigned hi);
      if (pos < lo) return lo;
      if (pos > hi) return hi;
      return pos;
   endfunction

   function automatic int unsigned slew_toward(input int unsigned cur,
                                               input int unsigned tgt,
                                               input int unsigned step);
      if (tgt > cur) return ((tgt - cur) > step) ? cur + step : tgt;
      return ((cur - tgt) > step) ? cur - step : tgt;
   endfunction

endpackage

// File: rtl/rc_pwm_multi_if.sv
// rtl/rc_pwm_multi_if.sv - position write port of rc_pwm_multi
interface rc_pwm_multi_if #(
   parameter int unsigned NUM_CH = 2,
   parameter int unsigned POS_W  = 8
);
   localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic              wr_valid;
   logic              wr_ready;
   logic [CH_W-1:0]   wr_ch;
   logic [POS_W-1:0]  wr_pos;
   logic              wr_err;

   modport master (output wr_valid, wr_ch, wr_pos, input wr_ready, wr_err);
   modport slave  (input wr_valid, wr_ch, wr_pos, output wr_ready, wr_err);

endinterface

// File: rtl/rc_pwm_channel.sv
// rtl/rc_pwm_channel.sv - one PWM channel: pending/active pair, clamp, slew, compare flop
// Optional RC_PWM_SLEW_EN: active moves at most SLEW_STEP toward pending per commit.
module rc_pwm_channel
   import rc_pwm_pkg::*;
#(
   parameter int unsigned POS_W     = DEF_POS_W,
   parameter int unsigned FW        = 9,
   parameter int unsigned MIN_POS   = DEF_MIN_POS,
   parameter int unsigned MAX_POS   = DEF_MAX_POS,
`ifdef RC_PWM_SLEW_EN
   parameter int unsigned SLEW_STEP = DEF_SLEW_STEP,
`endif
   parameter int unsigned NEUTRAL   = DEF_NEUTRAL
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable_i,
   input  logic             wr_en_i,
   input  logic [POS_W-1:0] wr_pos_i,
   input  logic             commit_i,
   input  logic [FW-1:0]    frame_cnt_i,
   output logic             pulse_o
);
   localparam int unsigned CW = (FW > POS_W) ? FW : POS_W;

   logic [POS_W-1:0] pending_q, pending_d;
   logic [POS_W-1:0] active_q, active_d;
   logic             pulse_q, pulse_d;

   always_comb begin
      pending_d = pending_q;
      active_d  = active_q;
      if (wr_en_i) begin
         pending_d = POS_W'(clamp_pos(32'(wr_pos_i), MIN_POS, MAX_POS));
      end
      // Writes are never accepted in a commit cycle, so pending_q is stable here.
      if (commit_i) begin
`ifdef RC_PWM_SLEW_EN
         active_d = POS_W'(slew_toward(32'(active_q), 32'(pending_q), SLEW_STEP));
`else
         active_d = pending_q;
`endif
      end
      pulse_d = enable_i && (CW'(frame_cnt_i) < CW'(active_q));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q <= POS_W'(NEUTRAL);
         active_q  <= POS_W'(NEUTRAL);
         pulse_q   <= 1'b0;
      end else begin
         pending_q <= pending_d;
         active_q  <= active_d;
         pulse_q   <= pulse_d;
      end
   end

   assign pulse_o = pulse_q;

endmodule

// File: rtl/rc_pwm_multi.sv
// rtl/rc_pwm_multi.sv - multi-channel RC servo/ESC pulse generator with shared divider
// Optional RC_PWM_SLEW_EN: slew-limited frame commits in every channel.
module rc_pwm_multi
   import rc_pwm_pkg::*;
#(
   parameter int unsigned NUM_CH      = 2,
   parameter int unsigned CLK_DIV     = DEF_CLK_DIV,
   parameter int unsigned FRAME_TICKS = DEF_FRAME_TICKS,
   parameter int unsigned POS_W       = DEF_POS_W,
   parameter int unsigned MIN_POS     = DEF_MIN_POS,
   parameter int unsigned MAX_POS     = DEF_MAX_POS,
   parameter int unsigned NEUTRAL     = DEF_NEUTRAL,
   parameter int unsigned SLEW_STEP   = DEF_SLEW_STEP
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   rc_pwm_multi_if.slave     wr,
   output logic              tick,
   output logic              frame_start,
   output logic [NUM_CH-1:0] pulse_out
);
   localparam int unsigned FW   = $clog2(FRAME_TICKS);
   localparam int unsigned DW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   // A zero slew step would freeze every output at NEUTRAL forever.
   if (NUM_CH < 1 || NUM_CH > 16 || MAX_POS >= FRAME_TICKS || MIN_POS > MAX_POS ||
       (1 << FW) != FRAME_TICKS || MAX_POS >= (1 << POS_W) || SLEW_STEP == 0) begin : g_bad_cfg
      $error("rc_pwm_multi: illegal parameter set");
   end

   logic [DW-1:0] div_cnt_q, div_cnt_d;
   logic [FW-1:0] frame_cnt_q, frame_cnt_d;
   logic          tick_q, tick_d;
   logic          frame_start_q;
   logic          wr_err_q, wr_err_d;
   logic          commit;
   logic          accept;

   always_comb begin
      div_cnt_d = div_cnt_q + DW'(1);
      tick_d    = 1'b0;
      if (div_cnt_q == DW'(CLK_DIV - 1)) begin
         div_cnt_d = '0;
         tick_d    = 1'b1;
      end
      commit      = tick_q && (frame_cnt_q == FW'(FRAME_TICKS - 1));
      frame_cnt_d = tick_q ? frame_cnt_q + FW'(1) : frame_cnt_q;
      accept      = wr.wr_valid && !commit;
      wr_err_d    = accept && (32'(wr.wr_ch) >= NUM_CH);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt_q     <= '0;
         frame_cnt_q   <= '0;
         tick_q        <= 1'b0;
         frame_start_q <= 1'b0;
         wr_err_q      <= 1'b0;
      end else begin
         div_cnt_q     <= div_cnt_d;
         frame_cnt_q   <= frame_cnt_d;
         tick_q        <= tick_d;
         frame_start_q <= commit;
         wr_err_q      <= wr_err_d;
      end
   end

   assign wr.wr_ready = !commit;
   assign wr.wr_err   = wr_err_q;
   assign tick        = tick_q;
   assign frame_start = frame_start_q;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      rc_pwm_channel #(
         .POS_W     (POS_W),
         .FW        (FW),
         .MIN_POS   (MIN_POS),
         .MAX_POS   (MAX_POS),
`ifdef RC_PWM_SLEW_EN
         .SLEW_STEP (SLEW_STEP),
`endif
         .NEUTRAL   (NEUTRAL)
      ) u_ch (
         .clk         (clk),
         .rst_n       (rst_n),
         .enable_i    (enable),
         .wr_en_i     (accept && (wr.wr_ch == CH_W'(i))),
         .wr_pos_i    (wr.wr_pos),
         .commit_i    (commit),
         .frame_cnt_i (frame_cnt_q),
         .pulse_o     (pulse_out[i])
      );
   end

endmodule

// File: tb/tb_rc_pwm_multi.sv
// tb/tb_rc_pwm_multi.sv - randomized self-checking bench for rc_pwm_multi against a cycle-count model
module tb_rc_pwm_multi;
   localparam int unsigned NUM_CH      = 3;
   localparam int unsigned CLK_DIV     = 4;
   localparam int unsigned FRAME_TICKS = 16;
   localparam int unsigned POS_W       = 8;
   localparam int unsigned MIN_POS     = 2;
   localparam int unsigned MAX_POS     = 12;
   localparam int unsigned NEUTRAL     = 6;
   localparam int unsigned SLEW_STEP   = 2;
   localparam int          FRAME_CYC   = CLK_DIV * FRAME_TICKS;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              enable;
   logic              tick;
   logic              frame_start;
   logic [NUM_CH-1:0] pulse_out;

   rc_pwm_multi_if #(.NUM_CH(NUM_CH), .POS_W(POS_W)) wr_if ();

   rc_pwm_multi #(
      .NUM_CH(NUM_CH), .CLK_DIV(CLK_DIV), .FRAME_TICKS(FRAME_TICKS), .POS_W(POS_W),
      .MIN_POS(MIN_POS), .MAX_POS(MAX_POS), .NEUTRAL(NEUTRAL), .SLEW_STEP(SLEW_STEP)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .wr(wr_if),
      .tick(tick), .frame_start(frame_start), .pulse_out(pulse_out)
   );

   always #5 clk = ~clk;

   int                vectors;
   int                miscompares;
   int                n;
   int                pend [NUM_CH];
   int                act  [NUM_CH];
   logic [NUM_CH-1:0] exp_pulse;
   bit                exp_fs;
   bit                exp_err;
   int                hi_cnt [NUM_CH];
   int                widths [NUM_CH][$];
   int                fs_cycles [$];
   int                rdy_low_cnt;
   int                err_cnt;
   int                exp_w [NUM_CH][3];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, n);
      end
   endtask

   function automatic int clamp_m(input int p);
      if (p < int'(MIN_POS)) return MIN_POS;
      if (p > int'(MAX_POS)) return MAX_POS;
      return p;
   endfunction

   // Divider and frame position follow directly from the cycle count since reset.
   function automatic bit tick_at(input int k);
      return (k > 0) && (k % CLK_DIV == 0);
   endfunction

   function automatic int frame_cnt_at(input int k);
      return (k == 0) ? 0 : ((k - 1) / CLK_DIV) % FRAME_TICKS;
   endfunction

   function automatic int next_active(input int a, input int p);
`ifdef RC_PWM_SLEW_EN
      int d;
      d = p - a;
      if (d > int'(SLEW_STEP))  d = SLEW_STEP;
      if (d < -int'(SLEW_STEP)) d = -int'(SLEW_STEP);
      return a + d;
`else
      return p;
`endif
   endfunction

   task automatic model_reset();
      n         = 0;
      exp_pulse = '0;
      exp_fs    = 1'b0;
      exp_err   = 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
         pend[c]   = NEUTRAL;
         act[c]    = NEUTRAL;
         hi_cnt[c] = 0;
      end
   endtask

   task automatic clear_widths();
      for (int c = 0; c < NUM_CH; c++) begin
         widths[c].delete();
         hi_cnt[c] = 0;
      end
      fs_cycles.delete();
   endtask

   // Called just after a falling edge with this cycle's inputs already driven.
   task automatic cycle();
      bit tk;
      bit cm;
      int fc;
      tk = tick_at(n);
      fc = frame_cnt_at(n);
      cm = tk && (fc == FRAME_TICKS - 1);
      check("tick", tick, tk);
      check("frame_start", frame_start, exp_fs);
      check("wr_ready", wr_if.wr_ready, !cm);
      check("wr_err", wr_if.wr_err, exp_err);
      check("pulse_out", pulse_out, exp_pulse);
      if (exp_fs) begin
         for (int c = 0; c < NUM_CH; c++) begin
            widths[c].push_back(hi_cnt[c]);
            hi_cnt[c] = 0;
         end
         fs_cycles.push_back(n);
      end
      for (int c = 0; c < NUM_CH; c++) if (pulse_out[c] === 1'b1) hi_cnt[c]++;
      if (wr_if.wr_ready !== 1'b1) rdy_low_cnt++;
      if (wr_if.wr_err === 1'b1) err_cnt++;
      for (int c = 0; c < NUM_CH; c++) exp_pulse[c] = (enable === 1'b1) && (fc < act[c]);
      exp_err = 1'b0;
      if (wr_if.wr_valid && !cm) begin
         if (int'(wr_if.wr_ch) < NUM_CH) pend[wr_if.wr_ch] = clamp_m(int'(wr_if.wr_pos));
         else exp_err = 1'b1;
      end
      if (cm) for (int c = 0; c < NUM_CH; c++) act[c] = next_active(act[c], pend[c]);
      exp_fs = cm;
      @(posedge clk);
      n++;
      @(negedge clk);
   endtask

   task automatic do_write(input int ch, input int pos);
      wr_if.wr_valid = 1'b1;
      wr_if.wr_ch    = ch[1:0];
      wr_if.wr_pos   = pos[POS_W-1:0];
      cycle();
      wr_if.wr_valid = 1'b0;
   endtask

   task automatic reset_checks(input string pfx);
      check({pfx, "_tick"}, tick, 0);
      check({pfx, "_frame_start"}, frame_start, 0);
      check({pfx, "_wr_ready"}, wr_if.wr_ready, 1);
      check({pfx, "_wr_err"}, wr_if.wr_err, 0);
      check({pfx, "_pulse_out"}, pulse_out, 0);
   endtask

   initial begin
      vectors        = 0;
      miscompares    = 0;
      rdy_low_cnt    = 0;
      err_cnt        = 0;
      rst_n          = 1'b0;
      enable         = 1'b0;
      wr_if.wr_valid = 1'b0;
      wr_if.wr_ch    = '0;
      wr_if.wr_pos   = '0;
      model_reset();
`ifdef RC_PWM_SLEW_EN
      exp_w = '{'{16, 8, 8}, '{32, 40, 40}, '{32, 40, 48}};
`else
      exp_w = '{'{8, 8, 8}, '{40, 40, 40}, '{48, 48, 48}};
`endif
      repeat (3) @(negedge clk);
      reset_checks("reset");
      rst_n  = 1'b1;
      enable = 1'b1;

      // Neutral frames straight out of reset.
      for (int i = 0; i < 4 * FRAME_CYC && fs_cycles.size() < 3; i++) cycle();
      check("neutral_frames_seen", fs_cycles.size(), 3);
      for (int c = 0; c < NUM_CH; c++) check($sformatf("neutral_width_ch%0d", c), widths[c][1], 24);
      check("frame_period", fs_cycles[1] - fs_cycles[0], FRAME_CYC);

      // Mid-frame writes, including both clamp limits.
      repeat (20) cycle();
      clear_widths();
      do_write(1, 10);
      do_write(0, 0);
      do_write(2, 15);
      for (int i = 0; i < 5 * FRAME_CYC && fs_cycles.size() < 4; i++) cycle();
      check("write_frames_seen", fs_cycles.size(), 4);
      for (int c = 0; c < NUM_CH; c++)
         for (int k = 0; k < 3; k++)
            check($sformatf("width_ch%0d_f%0d", c, k), widths[c][k+1], exp_w[c][k]);

      // Write held across a commit cycle.
      rdy_low_cnt    = 0;
      wr_if.wr_valid = 1'b1;
      wr_if.wr_ch    = 2'd1;
      wr_if.wr_pos   = 8'd7;
      for (int i = 0; i < 2 * FRAME_CYC && rdy_low_cnt == 0; i++) cycle();
      check("ready_after_commit", wr_if.wr_ready, 1);
      cycle();
      wr_if.wr_valid = 1'b0;
      check("ready_low_cycles", rdy_low_cnt, 1);

      // Out-of-range channel.
      err_cnt = 0;
      do_write(3, 5);
      repeat (3) cycle();
      check("wr_err_pulses", err_cnt, 1);

      // Enable dropped while channel 0 is high.
      for (int i = 0; i < 2 * FRAME_CYC && pulse_out[0] !== 1'b1; i++) cycle();
      check("pulse_before_disable", pulse_out[0], 1);
      enable = 1'b0;
      cycle();
      check("pulse_after_disable", pulse_out, 0);
      repeat (10) cycle();
      enable = 1'b1;

      // Random traffic.
      for (int i = 0; i < 1500; i++) begin
         wr_if.wr_valid = ($urandom_range(0, 2) == 0);
         wr_if.wr_ch    = 2'($urandom_range(0, 3));
         wr_if.wr_pos   = 8'($urandom_range(0, 20));
         if ($urandom_range(0, 49) == 0) enable = ~enable;
         cycle();
      end
      wr_if.wr_valid = 1'b0;
      enable         = 1'b1;

      // Asynchronous reset mid-frame.
      repeat (FRAME_CYC / 2 + 3) cycle();
      #2 rst_n = 1'b0;
      #1 reset_checks("async_reset");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      repeat (2 * FRAME_CYC + 5) cycle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/rc_pwm_multi.md
# rc_pwm_multi

Multi-channel RC servo/ESC pulse generator, the parametrised successor to the two-channel steering/throttle PWM. One shared clock divider and frame counter drive NUM_CH independent pulse outputs. Each channel is written over a valid/ready port and double-buffered so that a new position takes effect only at a frame boundary. Sits between the drive-control logic and the servo/ESC output pins.

## Interface
- NUM_CH, 2: number of PWM channels (1..16)
- CLK_DIV, 1953: clk cycles per tick
- FRAME_TICKS, 512: ticks per frame, power of two; frame counter width FW = log2(FRAME_TICKS)
- POS_W, 8: position width in ticks; must satisfy MAX_POS < FRAME_TICKS
- MIN_POS, 50: lower clamp (1 ms)
- MAX_POS, 100: upper clamp (2 ms)
- NEUTRAL, 75: reset and default position
- SLEW_STEP, 2: maximum change per frame when slew limiting is compiled in
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- enable  in  1  global output enable
- wr_valid  in  1  position write request
- wr_ready  out  1  write accepted when wr_valid && wr_ready
- wr_ch  in  max(1,clog2(NUM_CH))  target channel
- wr_pos  in  POS_W  requested position in ticks
- wr_err  out  1  one-cycle pulse: accepted write had wr_ch >= NUM_CH
- tick  out  1  one-cycle strobe, once per CLK_DIV cycles
- frame_start  out  1  one-cycle strobe on the cycle the frame counter wraps to 0
- pulse_out  out  NUM_CH  PWM outputs, bit i = channel i

## Operation
- div_cnt counts 0..CLK_DIV-1 and wraps. tick is registered: tick = 1 in the cycle after div_cnt == CLK_DIV-1.
- frame_cnt (FW bits) increments on tick and wraps FRAME_TICKS-1 -> 0.
- Commit cycle: tick && frame_cnt == FRAME_TICKS-1. In that same cycle frame_cnt -> 0, frame_start asserts, and every active[i] loads from pending[i].
- wr_ready = !commit_cycle (combinational). This guarantees a write never coincides with a commit.
- Accepted write with wr_ch < NUM_CH: pending[wr_ch] <= clamp(wr_pos, MIN_POS, MAX_POS).
- Accepted write with wr_ch >= NUM_CH: data is dropped and wr_err pulses in the next cycle.
- Repeated writes to the same channel within one frame: the last write wins.
- pulse_out[i] <= enable && (frame_cnt < active[i]), registered.
- High time = active[i] * CLK_DIV cycles. Period = FRAME_TICKS * CLK_DIV cycles.
- enable low forces pulse_out to 0 from the next cycle. Counters and commits keep running.
- enable rising mid-frame gives immediate comparison, so a partial first pulse is allowed.
- Reset values: div_cnt = frame_cnt = 0; pending = active = NEUTRAL; tick = frame_start = wr_err = 0; pulse_out = 0; wr_ready = 1.
- rst_n assertion mid-frame returns all state to the reset values immediately. After release, the first frame starts at frame_cnt = 0.

## Timing
- Write to pulse change: the write is visible from the first commit after acceptance, i.e. at most one frame plus one cycle.
- frame_start and the active update occur in the same cycle. pulse_out reflects the new active[i] one cycle later.
- tick, frame_start and wr_err are each exactly one cycle wide.
- wr_ready is low for exactly one cycle per frame.

## Configuration
- RC_PWM_SLEW_EN defined: at each commit, active[i] moves toward pending[i] by min(|pending[i] - active[i]|, SLEW_STEP). This limits servo and throttle jerk.
- RC_PWM_SLEW_EN undefined: active[i] = pending[i] at each commit, and the SLEW_STEP parameter is ignored.

## Structure
- Package rc_pwm_pkg holds:
  - default constants: NEUTRAL, MIN_POS, MAX_POS, FRAME_TICKS
  - clamp and slew step functions
- Sub-module rc_pwm_channel, one instance per channel, holds:
  - the pending/active register pair
  - the clamp and slew logic
  - the compare flop
- The top level owns the divider, frame counter, write decode and wr_err generation.

## Test plan
Small bench parameters: CLK_DIV=4, FRAME_TICKS=16, MIN_POS=2, MAX_POS=12, NEUTRAL=6, SLEW_STEP=2, NUM_CH=3.
- Reset release, no writes -> every channel high for 24 cycles out of each 64-cycle frame; tick every 4 cycles; frame_start every 64 cycles.
- Write ch1 = 10 mid-frame -> ch1 stays at 6 ticks until the next frame_start, then high for 40 cycles.
- Write ch0 = 0 and ch2 = 15 -> clamped: 2 ticks (8 cycles) and 12 ticks (48 cycles).
- wr_valid held through a commit cycle -> wr_ready low for exactly that cycle; write accepted the following cycle.
- Write wr_ch = 3 -> wr_err pulses once; no channel changes.
- With RC_PWM_SLEW_EN, write ch0 = 12 from 6 -> successive frame widths of 8, 10, 12 ticks. Without it -> 12 on the first frame. Deasserting enable mid-pulse -> pulse_out = 0 the next cycle.
